// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared definitions for the multi-cycle MIPS-subset control unit:
//   - opcode / func field constants for the supported instructions
//   - datapath mux and function encodings (ALU_*, EXT_*, REGDST_*, WD_*,
//     PCSRC_*, SRCA_*, SRCB_*)
//   - the controller state enum (13 states) and the instruction class enum
//     produced by mc_decode
package mc_ctrl_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // ALU function select
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_SLL = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  // Immediate extender mode
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // GRF write register select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // GRF write data select
  localparam logic [1:0] WD_ALUOUT = 2'b00;
  localparam logic [1:0] WD_MDR    = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  // ALU operand selects
  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_A       = 1'b1;
  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_EXT     = 2'd2;
  localparam logic [1:0] SRCB_EXT_SH2 = 2'd3;

  // Controller states
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_MEMADR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_JR
  } state_t;

  // Instruction classes used for dispatch out of DECODE
  typedef enum logic [2:0] {
    IC_R,
    IC_JR,
    IC_LOAD,
    IC_STORE,
    IC_IMM,
    IC_BR,
    IC_JMP,
    IC_BAD
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode
// Combinational instruction decoder for mc_ctrl.
// Ports:
//   op      in  6  IR[31:26]
//   func    in  6  IR[5:0]
//   iclass  out    instruction class (R, JR, LOAD, STORE, IMM, BR, JMP, BAD)
//   alu_op  out 3  ALU function for the execute step (R-type / ori / lui)
//   ext_op  out 2  extender mode for the execute step of ori / lui
//   is_jal  out 1  jump also links to $31
//   is_bne  out 1  branch condition is "not equal"
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output iclass_t    iclass,
  output logic [2:0] alu_op,
  output logic [1:0] ext_op,
  output logic       is_jal,
  output logic       is_bne
);

  always_comb begin
    iclass = IC_BAD;
    alu_op = ALU_ADD;
    ext_op = EXT_SIGN;
    is_jal = 1'b0;
    is_bne = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: begin iclass = IC_R; alu_op = ALU_ADD; end
          FN_SUBU: begin iclass = IC_R; alu_op = ALU_SUB; end
          FN_SLL:  begin iclass = IC_R; alu_op = ALU_SLL; end
          FN_SLT:  begin iclass = IC_R; alu_op = ALU_SLT; end
          FN_JR:   iclass = IC_JR;
          default: iclass = IC_BAD;
        endcase
      end
      OP_ORI: begin
        iclass = IC_IMM;
        alu_op = ALU_OR;
        ext_op = EXT_ZERO;
      end
      // lui is executed as (imm << 16) | $rs-free path: the EXT unit does the
      // shift and the ALU simply ORs it with A, which the assembler keeps at $0.
      OP_LUI: begin
        iclass = IC_IMM;
        alu_op = ALU_OR;
        ext_op = EXT_LUI;
      end
      OP_LW:  iclass = IC_LOAD;
      OP_SW:  iclass = IC_STORE;
      OP_BEQ: iclass = IC_BR;
      OP_BNE: begin
        iclass = IC_BR;
        is_bne = 1'b1;
      end
      OP_J:   iclass = IC_JMP;
      OP_JAL: begin
        iclass = IC_JMP;
        is_jal = 1'b1;
      end
      default: iclass = IC_BAD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl
// Multi-cycle control FSM for the MIPS-subset CPU. Sequences the shared
// datapath and a unified instruction/data memory behind a req/ready
// handshake, one instruction at a time.
// Ports:
//   clk, reset          clock; synchronous active-high reset (-> FETCH)
//   op, func, zero      IR fields and ALU zero flag
//   mem_ready           memory completes the current access this cycle
//   mem_req, mem_we,    memory request / store / address select
//   i_or_d
//   ir_we, mdr_we,      register write enables
//   pc_we, reg_we
//   pc_src, alu_src_a,  datapath mux selects
//   alu_src_b, ext_op,
//   alu_op, reg_dst,
//   wd_sel
//   instr_done          one-cycle pulse in the last state of an instruction
//   illegal             one-cycle pulse in DECODE for an unsupported op/func
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_we,
  output logic       mdr_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ext_op,
  output logic [2:0] alu_op,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state_reg;
  state_t     state_next;

  iclass_t    dec_class;
  logic [2:0] dec_alu_op;
  logic [1:0] dec_ext_op;
  logic       dec_is_jal;
  logic       dec_is_bne;

  mc_decode u_decode (
    .op     (op),
    .func   (func),
    .iclass (dec_class),
    .alu_op (dec_alu_op),
    .ext_op (dec_ext_op),
    .is_jal (dec_is_jal),
    .is_bne (dec_is_bne)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_B;
    ext_op     = EXT_ZERO;
    alu_op     = ALU_ADD;
    reg_we     = 1'b0;
    reg_dst    = REGDST_RT;
    wd_sel     = WD_ALUOUT;
    instr_done = 1'b0;
    illegal    = 1'b0;

    // While reset is high every output stays at its idle value, so no write
    // enable or memory access can slip out in the reset cycle even if the
    // memory happens to report ready. The state register is forced to FETCH
    // by the sequential block regardless of state_next.
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          // PC + 4 is computed by the ALU and written together with IR.
          mem_req   = 1'b1;
          i_or_d    = 1'b0;
          alu_src_a = SRCA_PC;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALU_ADD;
          pc_src    = PCSRC_ALU;
          if (mem_ready) begin
            ir_we      = 1'b1;
            pc_we      = 1'b1;
            state_next = S_DECODE;
          end
        end

        S_DECODE: begin
          // Speculatively form the branch target PC + (sext(imm) << 2) into
          // ALUOut; BRANCH consumes it via PCSRC_ALUOUT.
          alu_src_a = SRCA_PC;
          alu_src_b = SRCB_EXT_SH2;
          ext_op    = EXT_SIGN;
          alu_op    = ALU_ADD;
          case (dec_class)
            IC_R:     state_next = S_EXEC_R;
            IC_JR:    state_next = S_JR;
            IC_LOAD:  state_next = S_MEMADR;
            IC_STORE: state_next = S_MEMADR;
            IC_IMM:   state_next = S_EXEC_I;
            IC_BR:    state_next = S_BRANCH;
            IC_JMP:   state_next = S_JUMP;
            default: begin
              illegal    = 1'b1;
              instr_done = 1'b1;
              state_next = S_FETCH;
            end
          endcase
        end

        S_EXEC_R: begin
          alu_src_a  = SRCA_A;
          alu_src_b  = SRCB_B;
          alu_op     = dec_alu_op;
          state_next = S_WB_R;
        end

        S_WB_R: begin
          reg_we     = 1'b1;
          reg_dst    = REGDST_RD;
          wd_sel     = WD_ALUOUT;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end

        S_EXEC_I: begin
          alu_src_a  = SRCA_A;
          alu_src_b  = SRCB_EXT;
          alu_op     = ALU_OR;
          ext_op     = dec_ext_op;
          state_next = S_WB_I;
        end

        S_WB_I: begin
          reg_we     = 1'b1;
          reg_dst    = REGDST_RT;
          wd_sel     = WD_ALUOUT;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end

        S_MEMADR: begin
          alu_src_a = SRCA_A;
          alu_src_b = SRCB_EXT;
          ext_op    = EXT_SIGN;
          alu_op    = ALU_ADD;
          if (dec_class == IC_LOAD) begin
            state_next = S_MEM_RD;
          end else if (dec_class == IC_STORE) begin
            state_next = S_MEM_WR;
          end else begin
            // IR cannot change after FETCH; this only guards against an
            // upstream glitch on op and returns to a safe state.
            state_next = S_FETCH;
          end
        end

        S_MEM_RD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
          if (mem_ready) begin
            mdr_we     = 1'b1;
            state_next = S_WB_MEM;
          end
        end

        S_WB_MEM: begin
          reg_we     = 1'b1;
          reg_dst    = REGDST_RT;
          wd_sel     = WD_MDR;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end

        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          i_or_d  = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_next = S_FETCH;
          end
        end

        S_BRANCH: begin
          // ALU compares rs and rt by subtraction; zero is live this cycle.
          alu_src_a  = SRCA_A;
          alu_src_b  = SRCB_B;
          alu_op     = ALU_SUB;
          pc_src     = PCSRC_ALUOUT;
          pc_we      = dec_is_bne ? ~zero : zero;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end

        S_JUMP: begin
          pc_src     = PCSRC_JUMP;
          pc_we      = 1'b1;
          instr_done = 1'b1;
          // PC already holds PC + 4, which is exactly the jal link value.
          if (dec_is_jal) begin
            reg_we  = 1'b1;
            reg_dst = REGDST_RA;
            wd_sel  = WD_PC;
          end
          state_next = S_FETCH;
        end

        S_JR: begin
          pc_src     = PCSRC_RS;
          pc_we      = 1'b1;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end

        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule
